// File: rtl/dac_spi_tx.sv
// SPI (mode 0,0) transmitter for an MCP4911-class 10-bit DAC: frames a sample into a
// 16-bit command word, shifts it MSB first, then pulses LDAC. One-entry holding register.
module dac_spi_tx #(
    parameter int CLK_DIV = 25,
    parameter bit BUF     = 1'b0,
    parameter bit GA_N    = 1'b1
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic [9:0] data_in,
    input  logic       load,
    output logic       dac_cs_n,
    output logic       dac_sck,
    output logic       dac_sdi,
    output logic       dac_ldac_n,
    output logic       busy,
    output logic       overrun
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_LDAC  = 2'd3;

    localparam logic [7:0] HLAST = 8'(CLK_DIV - 1);

    function automatic logic [15:0] frame_word(input logic [9:0] d);
        return {1'b0, BUF, GA_N, 1'b1, d, 2'b00};
    endfunction

    logic [1:0]  state_q, state_d;
    logic [7:0]  hcnt_q, hcnt_d;
    logic [4:0]  half_q, half_d;
    logic [15:0] sh_q, sh_d;
    logic        pend_q, pend_d;
    logic [9:0]  pend_data_q, pend_data_d;
    logic        cs_n_q, cs_n_d;
    logic        sck_q, sck_d;
    logic        sdi_q, sdi_d;
    logic        ldac_n_q, ldac_n_d;
    logic        busy_q, busy_d;
    logic        ovr_q, ovr_d;

    logic        hend;
    logic        start;
    logic [9:0]  start_data;
    logic [15:0] start_word;

    always_comb begin
        state_d     = state_q;
        half_d      = half_q;
        sh_d        = sh_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        cs_n_d      = cs_n_q;
        sck_d       = sck_q;
        sdi_d       = sdi_q;
        ldac_n_d    = ldac_n_q;
        busy_d      = busy_q;
        start       = 1'b0;
        start_data  = data_in;
        start_word  = 16'h0000;

        hend   = (hcnt_q == HLAST);
        hcnt_d = hend ? 8'd0 : hcnt_q + 8'd1;

        // A load while busy always lands in the holding register; a second one overwrites it.
        ovr_d = load && (state_q != S_IDLE) && pend_q;
        if (load && (state_q != S_IDLE)) begin
            pend_d      = 1'b1;
            pend_data_d = data_in;
        end

        case (state_q)
            S_IDLE: begin
                hcnt_d = 8'd0;
                if (load) begin
                    start      = 1'b1;
                    start_data = data_in;
                end
            end
            S_SHIFT: begin
                if (hend) begin
                    if (half_q == 5'd31) begin
                        state_d = S_GAP;
                        cs_n_d  = 1'b1;
                        sck_d   = 1'b0;
                    end else begin
                        half_d = half_q + 5'd1;
                        sck_d  = ~sck_q;
                        if (sck_q) begin
                            sdi_d = sh_q[15];
                            sh_d  = {sh_q[14:0], 1'b0};
                        end
                    end
                end
            end
            S_GAP: begin
                if (hend) begin
                    state_d  = S_LDAC;
                    ldac_n_d = 1'b0;
                end
            end
            default: begin
                if (hend) begin
                    ldac_n_d = 1'b1;
                    // A load in this final cycle is treated as already pending.
                    if (pend_q || load) begin
                        start      = 1'b1;
                        start_data = load ? data_in : pend_data_q;
                        pend_d     = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
        endcase

        if (start) begin
            start_word = frame_word(start_data);
            state_d    = S_SHIFT;
            hcnt_d     = 8'd0;
            half_d     = 5'd0;
            cs_n_d     = 1'b0;
            sck_d      = 1'b0;
            sdi_d      = start_word[15];
            sh_d       = {start_word[14:0], 1'b0};
            busy_d     = 1'b1;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            hcnt_q      <= 8'd0;
            half_q      <= 5'd0;
            sh_q        <= 16'h0000;
            pend_q      <= 1'b0;
            pend_data_q <= 10'h000;
            cs_n_q      <= 1'b1;
            sck_q       <= 1'b0;
            sdi_q       <= 1'b0;
            ldac_n_q    <= 1'b1;
            busy_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            half_q      <= half_d;
            sh_q        <= sh_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            cs_n_q      <= cs_n_d;
            sck_q       <= sck_d;
            sdi_q       <= sdi_d;
            ldac_n_q    <= ldac_n_d;
            busy_q      <= busy_d;
            ovr_q       <= ovr_d;
        end
    end

    assign dac_cs_n   = cs_n_q;
    assign dac_sck    = sck_q;
    assign dac_sdi    = sdi_q;
    assign dac_ldac_n = ldac_n_q;
    assign busy       = busy_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Scoreboard bench for dac_spi_tx: stimulus queues expected frames and busy lengths,
// a negedge monitor reassembles SPI frames and compares them as they complete.
module tb_dac_spi_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] data_in = 10'h000;
    logic       load2 = 1'b0, load25 = 1'b0;

    logic cs2, sck2, sdi2, ldac2, busy2, ovr2;
    logic cs25, sck25, sdi25, ldac25, busy25, ovr25;

    dac_spi_tx #(.CLK_DIV(2)) dut2 (
        .sysclk(clk), .rst_n(rst_n), .data_in(data_in), .load(load2),
        .dac_cs_n(cs2), .dac_sck(sck2), .dac_sdi(sdi2), .dac_ldac_n(ldac2),
        .busy(busy2), .overrun(ovr2));

    dac_spi_tx #(.CLK_DIV(25)) dut25 (
        .sysclk(clk), .rst_n(rst_n), .data_in(data_in), .load(load25),
        .dac_cs_n(cs25), .dac_sck(sck25), .dac_sdi(sdi25), .dac_ldac_n(ldac25),
        .busy(busy25), .overrun(ovr25));

    always #5 clk = ~clk;

    logic sel = 1'b0;
    int   H = 2;
    logic m_cs, m_sck, m_sdi, m_ldac, m_busy, m_ovr;
    assign m_cs   = sel ? cs25   : cs2;
    assign m_sck  = sel ? sck25  : sck2;
    assign m_sdi  = sel ? sdi25  : sdi2;
    assign m_ldac = sel ? ldac25 : ldac2;
    assign m_busy = sel ? busy25 : busy2;
    assign m_ovr  = sel ? ovr25  : ovr2;

    int checks = 0;
    int errors = 0;

    logic [15:0] wq[$];
    int          cq[$];
    int          bq[$];

    int ldac_pulses = 0, ovr_cnt = 0, b2b_cnt = 0;
    bit idle_bad = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor
    initial begin
        logic p_cs, p_sck, p_sdi, p_ldac, p_busy;
        logic [15:0] shift;
        int bits, cs_len, ldac_len, busy_len, cyc, last_rise;
        bit sdi_bad, sck_bad;
        p_cs = 1'b1; p_sck = 1'b0; p_sdi = 1'b0; p_ldac = 1'b1; p_busy = 1'b0;
        shift = 16'h0; bits = 0; cs_len = 0; ldac_len = 0; busy_len = 0; cyc = 0;
        last_rise = -1; sdi_bad = 1'b0; sck_bad = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                bits = 0; cs_len = 0; ldac_len = 0; busy_len = 0; last_rise = -1;
            end else begin
                if (!m_cs && p_cs) begin
                    cs_len = 0; bits = 0; shift = 16'h0; last_rise = -1;
                    sdi_bad = 1'b0; sck_bad = 1'b0;
                    if (!p_ldac && m_ldac) b2b_cnt++;
                end
                if (!m_cs) begin
                    cs_len++;
                    if (m_sck && !p_sck) begin
                        shift = {shift[14:0], m_sdi};
                        bits++;
                        if (last_rise >= 0 && (cyc - last_rise) != 2 * H) sck_bad = 1'b1;
                        last_rise = cyc;
                    end
                    if (m_sck && p_sck && (m_sdi !== p_sdi)) sdi_bad = 1'b1;
                end else if (m_sck) begin
                    idle_bad = 1'b1;
                end
                if (m_cs && !p_cs) begin
                    if (wq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_frame: got word 0x%0h, expected no frame", shift);
                    end else begin
                        chk("frame_word", 32'(shift), 32'(wq.pop_front()));
                        chk("frame_bits", 32'(bits), 32'd16);
                        chk("cs_low_len", 32'(cs_len), 32'(cq.pop_front()));
                        chk("sdi_stable_sck_high", 32'(sdi_bad), 32'd0);
                        chk("sck_period", 32'(sck_bad), 32'd0);
                    end
                end
                if (!m_ldac) ldac_len++;
                if (m_ldac && !p_ldac) begin
                    ldac_pulses++;
                    chk("ldac_low_len", 32'(ldac_len), 32'(H));
                    ldac_len = 0;
                end
                if (m_busy) busy_len++;
                if (!m_busy && p_busy) begin
                    if (bq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_busy: got busy length %0d, expected none", busy_len);
                    end else begin
                        chk("busy_len", 32'(busy_len), 32'(bq.pop_front()));
                    end
                    busy_len = 0;
                end
                if (m_ovr) ovr_cnt++;
            end
            p_cs = m_cs; p_sck = m_sck; p_sdi = m_sdi; p_ldac = m_ldac; p_busy = m_busy;
        end
    end

    task automatic pulse_load(input logic [9:0] d);
        @(posedge clk);
        #1 data_in = d;
        if (sel) load25 = 1'b1; else load2 = 1'b1;
        @(posedge clk);
        #1 load2 = 1'b0; load25 = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (!m_busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL timeout_busy: got busy still high after %0d cycles, expected low", maxc);
        end
        repeat (5) @(posedge clk);
    endtask

    task automatic expect_frame(input logic [15:0] w);
        wq.push_back(w);
        cq.push_back(32 * H);
    endtask

    initial begin
        int l0, o0, b0;
        #12;
        chk("reset_outputs_h2", 32'({cs2, sck2, sdi2, ldac2, busy2, ovr2}), 32'b100100);
        chk("reset_outputs_h25", 32'({cs25, sck25, sdi25, ldac25, busy25, ovr25}), 32'b100100);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Single frame 10'h200
        l0 = ldac_pulses;
        expect_frame(16'h3800); bq.push_back(68);
        pulse_load(10'h200);
        wait_idle(200);
        chk("ldac_pulse_count_single", 32'(ldac_pulses - l0), 32'd1);

        // Sequential frames
        expect_frame(16'h3FFC); bq.push_back(68);
        pulse_load(10'h3FF);
        wait_idle(200);
        expect_frame(16'h3554); bq.push_back(68);
        pulse_load(10'h155);
        wait_idle(200);
        chk("sck_idle_low", 32'(idle_bad), 32'd0);

        // Back-to-back via pending
        o0 = ovr_cnt; b0 = b2b_cnt;
        expect_frame(16'h3000); expect_frame(16'h3AA8); bq.push_back(136);
        pulse_load(10'h000);
        repeat (8) @(posedge clk);
        pulse_load(10'h2AA);
        wait_idle(400);
        chk("b2b_start_on_ldac_rise", 32'(b2b_cnt - b0), 32'd1);
        chk("overrun_none", 32'(ovr_cnt - o0), 32'd0);

        // Overrun: two mid-frame loads, newest wins
        o0 = ovr_cnt;
        expect_frame(16'h33C0); expect_frame(16'h3888); bq.push_back(136);
        pulse_load(10'h0F0);
        repeat (8) @(posedge clk);
        pulse_load(10'h111);
        repeat (8) @(posedge clk);
        pulse_load(10'h222);
        wait_idle(400);
        chk("overrun_one_cycle_pulse", 32'(ovr_cnt - o0), 32'd1);

        // Asynchronous reset mid-frame with a sample pending
        pulse_load(10'h3FF);
        repeat (8) @(posedge clk);
        pulse_load(10'h155);
        repeat (18) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("async_reset_outputs", 32'({cs2, sck2, sdi2, ldac2, busy2, ovr2}), 32'b100100);
        l0 = ldac_pulses;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1 chk("pending_cleared_busy", 32'(m_busy), 32'd0);
        chk("no_ldac_after_reset", 32'(ldac_pulses - l0), 32'd0);
        expect_frame(16'h32A8); bq.push_back(68);
        pulse_load(10'h0AA);
        wait_idle(200);

        // CLK_DIV = 25
        sel = 1'b1; H = 25;
        repeat (3) @(posedge clk);
        expect_frame(16'h37FC); bq.push_back(850);
        pulse_load(10'h1FF);
        wait_idle(2000);

        chk("frames_outstanding", 32'(wq.size()), 32'd0);
        chk("busy_outstanding", 32'(bq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
